// File: rtl/dual_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// dual_fetch_queue_if
// Groups every handshake and bus signal of the dual fetch queue.
//   next-PC side : pcF1, pcF2 (slot A/B fetch PCs), flush (redirect), fetch_hold
//   imem request : imem_req_valid, imem_req_ready, imem_req_addr0/1
//   imem response: imem_rsp_valid, imem_rsp_data0/1 (in order, never stalled)
//   decode side  : out_valid, out_ready, out_pcA/out_instA, out_pcB/out_instB
//   status       : err_spurious (sticky)
// modport slave is used by the queue itself; modport master by its environment.
// ---------------------------------------------------------------------------
interface dual_fetch_queue_if;
   logic [31:0] pcF1;
   logic [31:0] pcF2;
   logic        flush;
   logic        fetch_hold;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr0;
   logic [31:0] imem_req_addr1;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data0;
   logic [31:0] imem_rsp_data1;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pcA;
   logic [31:0] out_instA;
   logic [31:0] out_pcB;
   logic [31:0] out_instB;
   logic        err_spurious;

   modport slave (
      input  pcF1, pcF2, flush, imem_req_ready, imem_rsp_valid,
             imem_rsp_data0, imem_rsp_data1, out_ready,
      output fetch_hold, imem_req_valid, imem_req_addr0, imem_req_addr1,
             out_valid, out_pcA, out_instA, out_pcB, out_instB, err_spurious
   );

   modport master (
      output pcF1, pcF2, flush, imem_req_ready, imem_rsp_valid,
             imem_rsp_data0, imem_rsp_data1, out_ready,
      input  fetch_hold, imem_req_valid, imem_req_addr0, imem_req_addr1,
             out_valid, out_pcA, out_instA, out_pcB, out_instB, err_spurious
   );
endinterface

// File: rtl/dual_fetch_queue.sv
// ---------------------------------------------------------------------------
// dual_fetch_queue
// Issues instruction-pair requests for the dual PC pair, tracks in-flight
// responses with a PC-tag queue, buffers returned pairs in a FIFO and presents
// the head to decode slots A/B.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : dual_fetch_queue_if.slave (next-PC, imem request/response,
//           decode output and sticky error signals)
// ---------------------------------------------------------------------------
module dual_fetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   dual_fetch_queue_if.slave bus
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

   logic [31:0]   pca_q   [DEPTH];
   logic [31:0]   pcb_q   [DEPTH];
   logic [31:0]   insta_q [DEPTH];
   logic [31:0]   instb_q [DEPTH];
   logic [31:0]   tag_a_q [MAX_OUTSTANDING];
   logic [31:0]   tag_b_q [MAX_OUTSTANDING];

   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [TW-1:0] twr_q, twr_d, trd_q, trd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [OW-1:0] out_q, out_d, drop_q, drop_d;
   logic          err_q, err_d;

   logic [31:0]   credit_s;
   logic          req_valid_s, fire_s, rsp_ok_s, drop_rsp_s, wr_s, pop_s;

   function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) fifo_inc = {PW{1'b0}};
      else                     fifo_inc = p + PW'(1);
   endfunction

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      if (p == TW'(MAX_OUTSTANDING - 1)) tag_inc = {TW{1'b0}};
      else                               tag_inc = p + TW'(1);
   endfunction

   // Issue and response qualification for the current cycle.
   always_comb begin
      // Slots already promised: buffered pairs plus responses that will be kept.
      credit_s    = 32'(cnt_q) + 32'(out_q) - 32'(drop_q);
      req_valid_s = rst_n & ~bus.flush & (32'(out_q) < MAX_OUTSTANDING) & (credit_s < DEPTH);
      fire_s      = req_valid_s & bus.imem_req_ready;
      // A response with nothing outstanding is spurious and otherwise ignored.
      rsp_ok_s    = bus.imem_rsp_valid & (out_q != {OW{1'b0}});
      drop_rsp_s  = rsp_ok_s & (drop_q != {OW{1'b0}});
      pop_s       = (cnt_q != {CW{1'b0}}) & bus.out_ready & ~bus.flush;
      // Credit makes a full-FIFO write impossible unless a pop frees a slot.
      wr_s        = rsp_ok_s & ~drop_rsp_s & ~bus.flush & ((cnt_q != CW'(DEPTH)) | pop_s);
   end

   // Next-state for pointers, counters and the sticky error.
   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      twr_d  = twr_q;
      trd_d  = trd_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      drop_d = drop_q;
      if (bus.imem_rsp_valid && (out_q == {OW{1'b0}})) err_d = 1'b1;
      else                                             err_d = err_q;

      if (bus.flush) begin
         // Everything still in flight becomes a response to discard.
         wr_d   = {PW{1'b0}};
         rd_d   = {PW{1'b0}};
         twr_d  = {TW{1'b0}};
         trd_d  = {TW{1'b0}};
         cnt_d  = {CW{1'b0}};
         out_d  = out_q - OW'(rsp_ok_s);
         drop_d = out_q - OW'(rsp_ok_s);
      end else begin
         out_d = out_q + OW'(fire_s) - OW'(rsp_ok_s);
         if (drop_rsp_s) drop_d = drop_q - OW'(1);
         else            drop_d = drop_q;
         if (fire_s) twr_d = tag_inc(twr_q);
         else        twr_d = twr_q;
         if (rsp_ok_s && !drop_rsp_s) trd_d = tag_inc(trd_q);
         else                         trd_d = trd_q;
         if (wr_s) wr_d = fifo_inc(wr_q);
         else      wr_d = wr_q;
         if (pop_s) rd_d = fifo_inc(rd_q);
         else       rd_d = rd_q;
         case ({wr_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= {PW{1'b0}};
         rd_q   <= {PW{1'b0}};
         twr_q  <= {TW{1'b0}};
         trd_q  <= {TW{1'b0}};
         cnt_q  <= {CW{1'b0}};
         out_q  <= {OW{1'b0}};
         drop_q <= {OW{1'b0}};
         err_q  <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         twr_q  <= twr_d;
         trd_q  <= trd_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         drop_q <= drop_d;
         err_q  <= err_d;
      end
   end

   // Tag and FIFO storage; validity is tracked by the counters, so no reset.
   always_ff @(posedge clk) begin
      if (fire_s) begin
         tag_a_q[twr_q] <= bus.pcF1;
         tag_b_q[twr_q] <= bus.pcF2;
      end
      if (wr_s) begin
         pca_q[wr_q]   <= tag_a_q[trd_q];
         pcb_q[wr_q]   <= tag_b_q[trd_q];
         insta_q[wr_q] <= bus.imem_rsp_data0;
         instb_q[wr_q] <= bus.imem_rsp_data1;
      end
   end

   assign bus.imem_req_valid = req_valid_s;
   assign bus.fetch_hold     = ~fire_s;
   assign bus.imem_req_addr0 = bus.pcF1;
   assign bus.imem_req_addr1 = bus.pcF2;
   assign bus.out_valid      = (cnt_q != {CW{1'b0}});
   assign bus.out_pcA        = pca_q[rd_q];
   assign bus.out_instA      = insta_q[rd_q];
   assign bus.out_pcB        = pcb_q[rd_q];
   assign bus.out_instB      = instb_q[rd_q];
   assign bus.err_spurious   = err_q;
endmodule
